store_forward_queue: RTL and testbench

Parametrised in-order store queue for the memory functional unit.
- Holds stores from dispatch until their address, data and ROB commit are all present, then drains them oldest-first to the memory port.
- Gives loads a same-cycle youngest-match forwarding / stall answer.
- Adds over the previous store buffer: configurable depth and widths, an in-order commit pointer with error flag, youngest-match priority, and flush of uncommitted stores.

---
 rtl/store_forward_queue.sv | 218 +++++++++++++++++++++
 tb/tb_store_forward_queue.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_forward_queue.sv
// store_forward_queue: in-order store queue. Stores wait for address, data and
// ROB commit, then drain oldest-first to memory. Loads get a same-cycle
// youngest-match forward or a stall answer.
module store_forward_queue #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 6
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  input  logic [ID_W-1:0]          alloc_id,
  input  logic [DATA_W-1:0]        alloc_data,
  input  logic                     alloc_data_ready,
  input  logic [ID_W-1:0]          alloc_data_tag,
  input  logic                     addr_valid,
  input  logic [ID_W-1:0]          addr_id,
  input  logic [ADDR_W-1:0]        addr,
  input  logic                     cdb_valid,
  input  logic [ID_W-1:0]          cdb_tag,
  input  logic [DATA_W-1:0]        cdb_data,
  input  logic                     commit_valid,
  input  logic [ID_W-1:0]          commit_id,
  input  logic                     flush,
  input  logic                     ld_valid,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_hit,
  output logic [DATA_W-1:0]        ld_data,
  output logic                     ld_stall,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_data,
  output logic [ID_W-1:0]          mem_id,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_commit
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Per-entry state
  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_addr_rdy;
  logic [DEPTH-1:0]  r_data_rdy;
  logic [DEPTH-1:0]  r_committed;
  logic [ID_W-1:0]   r_id   [DEPTH];
  logic [ID_W-1:0]   r_tag  [DEPTH];
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];

  // Pointers carry a wrap bit above the slot index
  logic [PW:0]       r_head;
  logic [PW:0]       r_cmt;
  logic [PW:0]       r_tail;
  logic [CW-1:0]     r_count;
  logic              r_err;

  logic [PW-1:0]     w_head_idx;
  logic [PW-1:0]     w_cmt_idx;
  logic [PW-1:0]     w_tail_idx;
  logic              w_full;
  logic              w_push;
  logic              w_mem_valid;
  logic              w_pop;
  logic              w_commit_ok;
  logic [PW:0]       w_cmt_next;
  logic [CW-1:0]     w_flush_n;
  logic [DEPTH-1:0]  w_flush_hit;
  logic              w_match;
  logic [PW-1:0]     w_match_idx;
  logic              w_unres;
  logic              w_ld_stall;
  logic              w_ld_hit;

  assign w_head_idx  = r_head[PW-1:0];
  assign w_cmt_idx   = r_cmt[PW-1:0];
  assign w_tail_idx  = r_tail[PW-1:0];
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_push      = alloc_valid && !w_full && !flush;
  assign w_mem_valid = r_valid[w_head_idx] && r_addr_rdy[w_head_idx] &&
                       r_data_rdy[w_head_idx] && r_committed[w_head_idx];
  assign w_pop       = w_mem_valid && mem_ready;
  // Only the entry at the commit pointer may commit; anything else is an ordering error
  assign w_commit_ok = commit_valid && (r_cmt != r_tail) && r_valid[w_cmt_idx] &&
                       (r_id[w_cmt_idx] == commit_id);
  assign w_cmt_next  = r_cmt + {{PW{1'b0}}, w_commit_ok};
  assign w_flush_n   = flush ? (r_tail - w_cmt_next) : {CW{1'b0}};

  // Mark the slots between the post-commit pointer and tail as flushed
  always_comb begin
    logic [PW-1:0] v_off;
    v_off       = {PW{1'b0}};
    w_flush_hit = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      v_off = PW'(i) - w_cmt_next[PW-1:0];
      if (flush && ({1'b0, v_off} < w_flush_n)) begin
        w_flush_hit[i] = 1'b1;
      end else begin
        w_flush_hit[i] = 1'b0;
      end
    end
  end

  // Load scan oldest to youngest so the last match seen is the youngest one
  always_comb begin
    logic [PW-1:0] v_idx;
    v_idx       = {PW{1'b0}};
    w_match     = 1'b0;
    w_match_idx = {PW{1'b0}};
    w_unres     = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      v_idx   = w_head_idx + PW'(k);
      w_unres = w_unres | (r_valid[v_idx] & ~r_addr_rdy[v_idx]);
      if (r_valid[v_idx] && r_addr_rdy[v_idx] && (r_addr[v_idx] == ld_addr)) begin
        w_match     = 1'b1;
        w_match_idx = v_idx;
      end else begin
        w_match     = w_match;
        w_match_idx = w_match_idx;
      end
    end
  end

  assign w_ld_stall = ld_valid && (w_unres || (w_match && !r_data_rdy[w_match_idx]));
  assign w_ld_hit   = ld_valid && !w_ld_stall && w_match;

  assign alloc_ready = !w_full;
  assign ld_stall    = w_ld_stall;
  assign ld_hit      = w_ld_hit;
  assign ld_data     = w_ld_hit ? r_data[w_match_idx] : {DATA_W{1'b0}};
  assign mem_valid   = w_mem_valid;
  assign mem_addr    = w_mem_valid ? r_addr[w_head_idx] : {ADDR_W{1'b0}};
  assign mem_data    = w_mem_valid ? r_data[w_head_idx] : {DATA_W{1'b0}};
  assign mem_id      = w_mem_valid ? r_id[w_head_idx]   : {ID_W{1'b0}};
  assign count       = r_count;
  assign err_commit  = r_err;

  // Entry storage: CDB/address capture, commit mark, push, pop, then flush wins
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_valid     <= {DEPTH{1'b0}};
      r_addr_rdy  <= {DEPTH{1'b0}};
      r_data_rdy  <= {DEPTH{1'b0}};
      r_committed <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_id[i]   <= {ID_W{1'b0}};
        r_tag[i]  <= {ID_W{1'b0}};
        r_addr[i] <= {ADDR_W{1'b0}};
        r_data[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_valid[i] && !r_data_rdy[i] && cdb_valid && (r_tag[i] == cdb_tag)) begin
          r_data[i]     <= cdb_data;
          r_data_rdy[i] <= 1'b1;
        end
        if (r_valid[i] && addr_valid && (r_id[i] == addr_id)) begin
          r_addr[i]     <= addr;
          r_addr_rdy[i] <= 1'b1;
        end
        if (w_commit_ok && (PW'(i) == w_cmt_idx)) begin
          r_committed[i] <= 1'b1;
        end
        if (w_push && (PW'(i) == w_tail_idx)) begin
          r_valid[i]     <= 1'b1;
          r_id[i]        <= alloc_id;
          r_tag[i]       <= alloc_data_tag;
          r_addr[i]      <= {ADDR_W{1'b0}};
          r_addr_rdy[i]  <= 1'b0;
          r_committed[i] <= 1'b0;
          if (alloc_data_ready) begin
            r_data[i]     <= alloc_data;
            r_data_rdy[i] <= 1'b1;
          end else if (cdb_valid && (cdb_tag == alloc_data_tag)) begin
            r_data[i]     <= cdb_data;
            r_data_rdy[i] <= 1'b1;
          end else begin
            r_data[i]     <= {DATA_W{1'b0}};
            r_data_rdy[i] <= 1'b0;
          end
        end
        if ((w_pop && (PW'(i) == w_head_idx)) || w_flush_hit[i]) begin
          r_valid[i]     <= 1'b0;
          r_addr_rdy[i]  <= 1'b0;
          r_data_rdy[i]  <= 1'b0;
          r_committed[i] <= 1'b0;
        end
      end
    end
  end

  // Pointers, occupancy and the sticky commit-order error
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_head  <= {(PW+1){1'b0}};
      r_cmt   <= {(PW+1){1'b0}};
      r_tail  <= {(PW+1){1'b0}};
      r_count <= {CW{1'b0}};
      r_err   <= 1'b0;
    end else begin
      r_head  <= r_head + {{PW{1'b0}}, w_pop};
      r_cmt   <= w_cmt_next;
      if (flush) begin
        r_tail <= w_cmt_next;
      end else begin
        r_tail <= r_tail + {{PW{1'b0}}, w_push};
      end
      r_count <= r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop} - w_flush_n;
      if (commit_valid && !w_commit_ok) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_store_forward_queue.sv
// Directed bench for store_forward_queue at DEPTH=4.
module tb_store_forward_queue;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int ID_W   = 6;

  logic              clk = 1'b0;
  logic              nrst;
  logic              alloc_valid, alloc_ready, alloc_data_ready;
  logic [ID_W-1:0]   alloc_id, alloc_data_tag, addr_id, cdb_tag, commit_id, mem_id;
  logic [DATA_W-1:0] alloc_data, cdb_data, ld_data, mem_data;
  logic              addr_valid, cdb_valid, commit_valid, flush, ld_valid;
  logic [ADDR_W-1:0] addr, ld_addr, mem_addr;
  logic              ld_hit, ld_stall, mem_valid, mem_ready, err_commit;
  logic [2:0]        count;

  int n_checks = 0;
  int n_fail   = 0;

  store_forward_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
    .clk(clk), .nrst(nrst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_id(alloc_id),
    .alloc_data(alloc_data), .alloc_data_ready(alloc_data_ready), .alloc_data_tag(alloc_data_tag),
    .addr_valid(addr_valid), .addr_id(addr_id), .addr(addr),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .commit_valid(commit_valid), .commit_id(commit_id), .flush(flush),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data), .ld_stall(ld_stall),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_id(mem_id), .count(count), .err_commit(err_commit)
  );

  always #5 clk = ~clk;

  task automatic idle();
    alloc_valid = 1'b0; alloc_id = '0; alloc_data = '0; alloc_data_ready = 1'b0; alloc_data_tag = '0;
    addr_valid = 1'b0; addr_id = '0; addr = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    commit_valid = 1'b0; commit_id = '0; flush = 1'b0;
    ld_valid = 1'b0; ld_addr = '0; mem_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic do_reset();
    idle();
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
  endtask

  task automatic push(input logic [ID_W-1:0] id, input logic [DATA_W-1:0] d,
                      input logic drdy, input logic [ID_W-1:0] tag);
    alloc_valid = 1'b1; alloc_id = id; alloc_data = d; alloc_data_ready = drdy; alloc_data_tag = tag;
    tick();
  endtask

  task automatic resolve(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] a);
    addr_valid = 1'b1; addr_id = id; addr = a;
    tick();
  endtask

  task automatic commit(input logic [ID_W-1:0] id);
    commit_valid = 1'b1; commit_id = id;
    tick();
  endtask

  task automatic pop();
    mem_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    nrst = 1'b0;
    ld_valid = 1'b1; ld_addr = 32'h0;
    #12;
    n_checks++;
    if (mem_valid !== 1'b0 || ld_hit !== 1'b0 || ld_stall !== 1'b0 || alloc_ready !== 1'b1 ||
        count !== 3'd0 || err_commit !== 1'b0 || mem_addr !== 32'h0 || mem_data !== 32'h0 ||
        mem_id !== 6'd0 || ld_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: mv=%0b hit=%0b stall=%0b ar=%0b cnt=%0d err=%0b ma=%h md=%h mi=%0d ld=%h, expected 0 0 0 1 0 0 all-zero",
               mem_valid, ld_hit, ld_stall, alloc_ready, count, err_commit, mem_addr, mem_data, mem_id, ld_data);
    end
    @(posedge clk); #1 nrst = 1'b1;
    idle();
    tick();
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 4; i++) push(ID_W'(i), 32'(i * 16), 1'b1, 6'd0);
    n_checks++;
    if (alloc_ready !== 1'b0 || count !== 3'd4) begin
      n_fail++; $display("FAIL full: ar=%0b cnt=%0d, expected ar=0 cnt=4", alloc_ready, count);
    end
    alloc_valid = 1'b1; alloc_id = 6'd7; alloc_data_ready = 1'b1;
    tick();
    n_checks++;
    if (count !== 3'd4) begin
      n_fail++; $display("FAIL push_when_full: cnt=%0d, expected 4", count);
    end
    for (int i = 1; i <= 4; i++) resolve(ID_W'(i), 32'h1000 + 32'(4 * i));
    n_checks++;
    if (mem_valid !== 1'b0) begin
      n_fail++; $display("FAIL uncommitted_hold: mv=%0b, expected 0", mem_valid);
    end
    commit(6'd1);
    n_checks++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h1004 || mem_data !== 32'h10 || mem_id !== 6'd1) begin
      n_fail++; $display("FAIL head_issue: mv=%0b ma=%h md=%h mi=%0d, expected 1 1004 10 1",
                         mem_valid, mem_addr, mem_data, mem_id);
    end
    pop();
    n_checks++;
    if (count !== 3'd3 || alloc_ready !== 1'b1 || mem_valid !== 1'b0) begin
      n_fail++; $display("FAIL after_pop: cnt=%0d ar=%0b mv=%0b, expected 3 1 0", count, alloc_ready, mem_valid);
    end
    commit(6'd2); pop();
    commit(6'd3); pop();
    commit(6'd4);
    n_checks++;
    if (mem_valid !== 1'b1 || mem_data !== 32'h40 || mem_addr !== 32'h1010 || mem_id !== 6'd4) begin
      n_fail++; $display("FAIL last_slot_issue: mv=%0b ma=%h md=%h mi=%0d, expected 1 1010 40 4",
                         mem_valid, mem_addr, mem_data, mem_id);
    end
    pop();
    n_checks++;
    if (count !== 3'd0 || mem_valid !== 1'b0) begin
      n_fail++; $display("FAIL drained: cnt=%0d mv=%0b, expected 0 0", count, mem_valid);
    end
  endtask

  task automatic test_cdb();
    cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'hDEAD;
    push(6'd5, 32'h0, 1'b0, 6'd9);
    resolve(6'd5, 32'h500);
    ld_valid = 1'b1; ld_addr = 32'h500; #1;
    n_checks++;
    if (ld_hit !== 1'b1 || ld_stall !== 1'b0 || ld_data !== 32'hDEAD) begin
      n_fail++; $display("FAIL cdb_on_push: hit=%0b stall=%0b data=%h, expected 1 0 dead", ld_hit, ld_stall, ld_data);
    end
    tick();
    cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'hBEEF;
    tick();
    ld_valid = 1'b1; ld_addr = 32'h500; #1;
    n_checks++;
    if (ld_hit !== 1'b1 || ld_data !== 32'hDEAD) begin
      n_fail++; $display("FAIL cdb_no_recapture: hit=%0b data=%h, expected 1 dead", ld_hit, ld_data);
    end
    tick();
    commit(6'd5);
    n_checks++;
    if (mem_valid !== 1'b1 || mem_data !== 32'hDEAD || mem_id !== 6'd5 || mem_addr !== 32'h500) begin
      n_fail++; $display("FAIL wrap_issue: mv=%0b ma=%h md=%h mi=%0d, expected 1 500 dead 5",
                         mem_valid, mem_addr, mem_data, mem_id);
    end
    pop();
    push(6'd6, 32'h0, 1'b0, 6'd10);
    resolve(6'd6, 32'h600);
    ld_valid = 1'b1; ld_addr = 32'h600; #1;
    n_checks++;
    if (ld_hit !== 1'b0 || ld_stall !== 1'b1) begin
      n_fail++; $display("FAIL data_wait_stall: hit=%0b stall=%0b, expected 0 1", ld_hit, ld_stall);
    end
    tick();
    cdb_valid = 1'b1; cdb_tag = 6'd10; cdb_data = 32'h66;
    tick();
    ld_valid = 1'b1; ld_addr = 32'h600; #1;
    n_checks++;
    if (ld_hit !== 1'b1 || ld_stall !== 1'b0 || ld_data !== 32'h66) begin
      n_fail++; $display("FAIL cdb_later: hit=%0b stall=%0b data=%h, expected 1 0 66", ld_hit, ld_stall, ld_data);
    end
    tick();
  endtask

  task automatic test_forward();
    do_reset();
    push(6'd1, 32'h11, 1'b1, 6'd0);
    push(6'd2, 32'h22, 1'b1, 6'd0);
    resolve(6'd1, 32'h100);
    resolve(6'd2, 32'h100);
    ld_valid = 1'b1; ld_addr = 32'h100; #1;
    n_checks++;
    if (ld_hit !== 1'b1 || ld_stall !== 1'b0 || ld_data !== 32'h22) begin
      n_fail++; $display("FAIL fwd_youngest: hit=%0b stall=%0b data=%h, expected 1 0 22", ld_hit, ld_stall, ld_data);
    end
    tick();
    ld_valid = 1'b1; ld_addr = 32'h104; #1;
    n_checks++;
    if (ld_hit !== 1'b0 || ld_stall !== 1'b0 || ld_data !== 32'h0) begin
      n_fail++; $display("FAIL fwd_miss: hit=%0b stall=%0b data=%h, expected 0 0 0", ld_hit, ld_stall, ld_data);
    end
    tick();
    do_reset();
    push(6'd1, 32'h11, 1'b1, 6'd0);
    push(6'd2, 32'h0, 1'b0, 6'd12);
    resolve(6'd1, 32'h100);
    resolve(6'd2, 32'h100);
    ld_valid = 1'b1; ld_addr = 32'h100; #1;
    n_checks++;
    if (ld_hit !== 1'b0 || ld_stall !== 1'b1) begin
      n_fail++; $display("FAIL fwd_young_not_ready: hit=%0b stall=%0b, expected 0 1", ld_hit, ld_stall);
    end
    tick();
    cdb_valid = 1'b1; cdb_tag = 6'd12; cdb_data = 32'h22;
    tick();
  endtask

  task automatic test_unresolved();
    push(6'd3, 32'h33, 1'b1, 6'd0);
    ld_valid = 1'b1; ld_addr = 32'h100; #1;
    n_checks++;
    if (ld_hit !== 1'b0 || ld_stall !== 1'b1) begin
      n_fail++; $display("FAIL unresolved_stall: hit=%0b stall=%0b, expected 0 1", ld_hit, ld_stall);
    end
    ld_valid = 1'b0; #1;
    n_checks++;
    if (ld_hit !== 1'b0 || ld_stall !== 1'b0 || ld_data !== 32'h0) begin
      n_fail++; $display("FAIL ld_idle: hit=%0b stall=%0b data=%h, expected 0 0 0", ld_hit, ld_stall, ld_data);
    end
    tick();
    resolve(6'd40, 32'h300);
    ld_valid = 1'b1; ld_addr = 32'h300; #1;
    n_checks++;
    if (ld_stall !== 1'b1 || count !== 3'd3) begin
      n_fail++; $display("FAIL unmatched_addr_id: stall=%0b cnt=%0d, expected 1 3", ld_stall, count);
    end
    tick();
    resolve(6'd3, 32'h200);
    ld_valid = 1'b1; ld_addr = 32'h300; #1;
    n_checks++;
    if (ld_hit !== 1'b0 || ld_stall !== 1'b0) begin
      n_fail++; $display("FAIL resolved_miss: hit=%0b stall=%0b, expected 0 0", ld_hit, ld_stall);
    end
    ld_addr = 32'h200; #1;
    n_checks++;
    if (ld_hit !== 1'b1 || ld_data !== 32'h33) begin
      n_fail++; $display("FAIL resolved_hit: hit=%0b data=%h, expected 1 33", ld_hit, ld_data);
    end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 1; i <= 3; i++) push(ID_W'(i), 32'(i), 1'b1, 6'd0);
    for (int i = 1; i <= 3; i++) resolve(ID_W'(i), 32'(i * 16));
    commit(6'd1);
    flush = 1'b1; commit_valid = 1'b1; commit_id = 6'd2;
    alloc_valid = 1'b1; alloc_id = 6'd20; alloc_data_ready = 1'b1; #1;
    n_checks++;
    if (alloc_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_alloc_ready: ar=%0b, expected 1", alloc_ready);
    end
    tick();
    n_checks++;
    if (count !== 3'd2 || err_commit !== 1'b0) begin
      n_fail++; $display("FAIL flush_count: cnt=%0d err=%0b, expected 2 0", count, err_commit);
    end
    n_checks++;
    if (mem_valid !== 1'b1 || mem_id !== 6'd1) begin
      n_fail++; $display("FAIL flush_keep1: mv=%0b mi=%0d, expected 1 1", mem_valid, mem_id);
    end
    pop();
    n_checks++;
    if (mem_valid !== 1'b1 || mem_id !== 6'd2 || mem_addr !== 32'h20) begin
      n_fail++; $display("FAIL flush_keep2: mv=%0b mi=%0d ma=%h, expected 1 2 20", mem_valid, mem_id, mem_addr);
    end
    pop();
    tick(); tick();
    n_checks++;
    if (mem_valid !== 1'b0 || count !== 3'd0) begin
      n_fail++; $display("FAIL flushed_not_issued: mv=%0b mi=%0d cnt=%0d, expected 0 - 0", mem_valid, mem_id, count);
    end
    push(6'd9, 32'h99, 1'b1, 6'd0);
    resolve(6'd9, 32'h900);
    commit(6'd9);
    n_checks++;
    if (mem_valid !== 1'b1 || mem_id !== 6'd9 || err_commit !== 1'b0 || count !== 3'd1) begin
      n_fail++; $display("FAIL post_flush_push: mv=%0b mi=%0d err=%0b cnt=%0d, expected 1 9 0 1",
                         mem_valid, mem_id, err_commit, count);
    end
    pop();
  endtask

  task automatic test_err_commit();
    do_reset();
    push(6'd1, 32'hA1, 1'b1, 6'd0);
    push(6'd2, 32'hA2, 1'b1, 6'd0);
    resolve(6'd1, 32'h10);
    resolve(6'd2, 32'h20);
    commit(6'd2);
    n_checks++;
    if (err_commit !== 1'b1 || count !== 3'd2 || mem_valid !== 1'b0) begin
      n_fail++; $display("FAIL ooo_commit: err=%0b cnt=%0d mv=%0b, expected 1 2 0", err_commit, count, mem_valid);
    end
    commit(6'd1);
    n_checks++;
    if (err_commit !== 1'b1 || mem_valid !== 1'b1 || mem_data !== 32'hA1) begin
      n_fail++; $display("FAIL err_sticky: err=%0b mv=%0b md=%h, expected 1 1 a1", err_commit, mem_valid, mem_data);
    end
    nrst = 1'b0; #1;
    n_checks++;
    if (mem_valid !== 1'b0 || count !== 3'd0 || err_commit !== 1'b0 || alloc_ready !== 1'b1) begin
      n_fail++; $display("FAIL async_reset: mv=%0b cnt=%0d err=%0b ar=%0b, expected 0 0 0 1",
                         mem_valid, count, err_commit, alloc_ready);
    end
    #2 nrst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_cdb();
    test_forward();
    test_unresolved();
    test_flush();
    test_err_commit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
